mc_ctrl: RTL

//  Multi-cycle MIPS control unit; the sequential successor to the single-cycle decoder.
//  It steps each instruction through the FETCH/DECODE/EXEC/MEM/WB states.
//  It handshakes with instruction and data memory and stalls on a fixed-latency multiplier.
//  It drives the same datapath control encodings as single-cycle ctrl: ALUctr, Branch, Jump, MemWr, MemRead.

---
 rtl/mc_ctrl.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB/MULW and
// drives the datapath control fields from the instruction fields latched at fetch.
module mc_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 4,
  parameter bit EN_MUL  = 1'b1,
  parameter bit EN_CP0  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic [4:0] rb,
  input  logic [2:0] cp0_op,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       ir_wr,
  output logic       pc_wr,
  output logic [3:0] ALUctr,
  output logic [2:0] Branch,
  output logic [1:0] Jump,
  output logic       RegDst,
  output logic       ALUsrc,
  output logic       ExtOp,
  output logic       ALUshf,
  output logic       MemtoReg,
  output logic       R31Wr,
  output logic       RegWr,
  output logic [1:0] MemWr,
  output logic [1:0] MemRead,
  output logic       mul_start,
  output logic       exc,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MULW   = 3'd5
  } state_e;

  // Instruction class: decides where EXEC goes next.
  typedef enum logic [2:0] {
    K_ILL, K_WB, K_LINK, K_FETCH, K_LOAD, K_STORE, K_MUL, K_SYS
  } cls_e;

  typedef struct packed {
    cls_e       cls;
    logic [3:0] alu;
    logic       reg_dst;
    logic       alu_src;
    logic       ext_op;
    logic       alu_shf;
    logic [2:0] branch;
    logic [1:0] jump;
    logic [1:0] mem_wr;
    logic [1:0] mem_read;
  } dec_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       func_q, func_d;
  logic [4:0]       rb_q, rb_d;
  logic [2:0]       cp0_q, cp0_d;
  dec_t             dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      op_q    <= '0;
      func_q  <= '0;
      rb_q    <= '0;
      cp0_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      func_q  <= func_d;
      rb_q    <= rb_d;
      cp0_q   <= cp0_d;
    end
  end

  // Decode from the latched fields only; anything unmatched stays K_ILL with zeroed fields.
  always_comb begin
    dec     = '0;
    dec.cls = K_ILL;
    case (op_q)
      6'h00: begin
        case (func_q)
          6'h21: begin dec.cls = K_WB; dec.alu = 4'h0; dec.reg_dst = 1'b1; end
          6'h23: begin dec.cls = K_WB; dec.alu = 4'h1; dec.reg_dst = 1'b1; end
          6'h2A: begin dec.cls = K_WB; dec.alu = 4'h2; dec.reg_dst = 1'b1; end
          6'h2B: begin dec.cls = K_WB; dec.alu = 4'h9; dec.reg_dst = 1'b1; end
          6'h24: begin dec.cls = K_WB; dec.alu = 4'h3; dec.reg_dst = 1'b1; end
          6'h25: begin dec.cls = K_WB; dec.alu = 4'h5; dec.reg_dst = 1'b1; end
          6'h26: begin dec.cls = K_WB; dec.alu = 4'h6; dec.reg_dst = 1'b1; end
          6'h27: begin dec.cls = K_WB; dec.alu = 4'h4; dec.reg_dst = 1'b1; end
          6'h00: begin dec.cls = K_WB; dec.alu = 4'h7; dec.reg_dst = 1'b1; dec.alu_shf = 1'b1; end
          6'h02: begin dec.cls = K_WB; dec.alu = 4'h8; dec.reg_dst = 1'b1; dec.alu_shf = 1'b1; end
          6'h03: begin dec.cls = K_WB; dec.alu = 4'hA; dec.reg_dst = 1'b1; dec.alu_shf = 1'b1; end
          6'h04: begin dec.cls = K_WB; dec.alu = 4'h7; dec.reg_dst = 1'b1; end
          6'h06: begin dec.cls = K_WB; dec.alu = 4'h8; dec.reg_dst = 1'b1; end
          6'h07: begin dec.cls = K_WB; dec.alu = 4'hA; dec.reg_dst = 1'b1; end
          6'h08: begin dec.cls = K_FETCH; dec.jump = 2'b10; end
          6'h09: begin dec.cls = K_LINK;  dec.jump = 2'b10; end
          6'h0C: if (EN_CP0) dec.cls = K_SYS;
          6'h10, 6'h12: if (EN_MUL) begin dec.cls = K_WB; dec.reg_dst = 1'b1; end
          6'h11, 6'h13: if (EN_MUL) dec.cls = K_FETCH;
          6'h18: if (EN_MUL) dec.cls = K_MUL;
          default: ;
        endcase
      end
      6'h01: begin
        if (rb_q == 5'h00) begin dec.cls = K_FETCH; dec.alu = 4'h1; dec.branch = 3'd6; end
        else if (rb_q == 5'h01) begin dec.cls = K_FETCH; dec.alu = 4'h1; dec.branch = 3'd3; end
      end
      6'h02: begin dec.cls = K_FETCH; dec.jump = 2'b01; end
      6'h03: begin dec.cls = K_LINK;  dec.jump = 2'b01; end
      6'h04: begin dec.cls = K_FETCH; dec.alu = 4'h1; dec.branch = 3'd1; end
      6'h05: begin dec.cls = K_FETCH; dec.alu = 4'h1; dec.branch = 3'd2; end
      6'h06: begin dec.cls = K_FETCH; dec.alu = 4'h1; dec.branch = 3'd5; end
      6'h07: begin dec.cls = K_FETCH; dec.alu = 4'h1; dec.branch = 3'd4; end
      6'h09: begin dec.cls = K_WB; dec.alu = 4'h0; dec.alu_src = 1'b1; dec.ext_op = 1'b1; end
      6'h0A: begin dec.cls = K_WB; dec.alu = 4'h2; dec.alu_src = 1'b1; dec.ext_op = 1'b1; end
      6'h0B: begin dec.cls = K_WB; dec.alu = 4'h9; dec.alu_src = 1'b1; dec.ext_op = 1'b1; end
      6'h0C: begin dec.cls = K_WB; dec.alu = 4'h3; dec.alu_src = 1'b1; end
      6'h0D: begin dec.cls = K_WB; dec.alu = 4'h5; dec.alu_src = 1'b1; end
      6'h0E: begin dec.cls = K_WB; dec.alu = 4'h6; dec.alu_src = 1'b1; end
      6'h0F: begin dec.cls = K_WB; dec.alu = 4'hB; dec.alu_src = 1'b1; end
      6'h10: if (EN_CP0) dec.cls = (cp0_q == 3'b001) ? K_WB : K_FETCH;
      6'h20: begin dec.cls = K_LOAD; dec.alu_src = 1'b1; dec.ext_op = 1'b1; dec.mem_read = 2'b10; end
      6'h23: begin dec.cls = K_LOAD; dec.alu_src = 1'b1; dec.ext_op = 1'b1; dec.mem_read = 2'b01; end
      6'h24: begin dec.cls = K_LOAD; dec.alu_src = 1'b1; dec.ext_op = 1'b1; dec.mem_read = 2'b11; end
      6'h28: begin dec.cls = K_STORE; dec.alu_src = 1'b1; dec.ext_op = 1'b1; dec.mem_wr = 2'b10; end
      6'h2B: begin dec.cls = K_STORE; dec.alu_src = 1'b1; dec.ext_op = 1'b1; dec.mem_wr = 2'b01; end
      default: ;
    endcase
  end

  // Handshake: a req stays high for the whole FETCH/MEM residency and the
  // transfer completes in any cycle where its ack is high (same-cycle ack
  // included); an ack seen in any other state is ignored.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    func_d    = func_q;
    rb_d      = rb_q;
    cp0_d     = cp0_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    ir_wr     = 1'b0;
    pc_wr     = 1'b0;
    ALUctr    = 4'h0;
    Branch    = 3'd0;
    Jump      = 2'b00;
    RegDst    = 1'b0;
    ALUsrc    = 1'b0;
    ExtOp     = 1'b0;
    ALUshf    = 1'b0;
    MemtoReg  = 1'b0;
    R31Wr     = 1'b0;
    RegWr     = 1'b0;
    MemWr     = 2'b00;
    MemRead   = 2'b00;
    mul_start = 1'b0;
    exc       = 1'b0;
    illegal   = 1'b0;
    if (state_q != S_FETCH) begin
      ALUctr = dec.alu;
      RegDst = dec.reg_dst;
      ALUsrc = dec.alu_src;
      ExtOp  = dec.ext_op;
      ALUshf = dec.alu_shf;
    end
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          op_d    = op;
          func_d  = func;
          rb_d    = rb;
          cp0_d   = cp0_op;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        Branch = dec.branch;
        Jump   = dec.jump;
        case (dec.cls)
          K_WB, K_LINK:     state_d = S_WB;
          K_LOAD, K_STORE:  state_d = S_MEM;
          K_MUL: begin
            cnt_d   = CNT_LOAD;
            state_d = S_MULW;
          end
          K_SYS: begin
            exc     = 1'b1;
            state_d = S_FETCH;
          end
          K_ILL: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        MemWr    = dec.mem_wr;
        MemRead  = dec.mem_read;
        if (dmem_ack) state_d = (dec.cls == K_LOAD) ? S_WB : S_FETCH;
      end
      S_WB: begin
        RegWr    = 1'b1;
        MemtoReg = (dec.cls == K_LOAD);
        R31Wr    = (dec.cls == K_LINK);
        state_d  = S_FETCH;
      end
      S_MULW: begin
        // The counter only falls, so the load value marks the first MULW cycle.
        mul_start = (cnt_q == CNT_LOAD);
        if (cnt_q == '0) state_d = S_FETCH;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign state = state_q;

endmodule
